// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame geometry and parity helper.
// Used by the TX core today and intended for the RX core as well.
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;
   localparam int DATA_BITS_MAX  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;

   // Parity over the low nbits of data; odd=1 inverts the plain XOR.
   function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data,
                                       input int nbits,
                                       input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < DATA_BITS_MAX; i++) begin
         if (i < nbits) p = p ^ data[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART transmit engine: serialises one latched word LSB-first as start, data,
// optional parity and one or two stop bits, timed by an oversampled baud strobe.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   uart_tx_state_e       state;
   logic [CW-1:0]        tick_cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_q;
   logic                 par_en_q;
   logic                 stop2_q;
   logic                 stop_idx;
   logic                 bit_end;

   assign bit_end = baud_tick && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         stop_idx <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         // Free-running within a bit; every state change below re-clears it.
         if (baud_tick) tick_cnt <= tick_cnt + 1'b1;

         case (state)
            IDLE: begin
               tick_cnt <= '0;
               if (tx_valid) begin
                  shreg    <= tx_data;
                  par_q    <= parity_bit(DATA_BITS_MAX'(tx_data), DATA_BITS, parity_odd);
                  par_en_q <= parity_en;
                  stop2_q  <= stop2;
                  state    <= START;
                  tx       <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
               end
            end

            START: begin
               if (bit_end) begin
                  state    <= DATA;
                  tick_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shreg[0];
               end
            end

            DATA: begin
               if (bit_end) begin
                  tick_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     stop_idx <= 1'b0;
                     if (par_en_q) begin
                        state <= PARITY;
                        tx    <= par_q;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
            end

            PARITY: begin
               if (bit_end) begin
                  state    <= STOP;
                  tick_cnt <= '0;
                  stop_idx <= 1'b0;
                  tx       <= 1'b1;
               end
            end

            STOP: begin
               if (bit_end) begin
                  tick_cnt <= '0;
                  if (stop2_q && !stop_idx) begin
                     stop_idx <= 1'b1;
                  end else begin
                     // Ready reasserts with done so a held tx_valid starts the next frame with no gap.
                     state    <= IDLE;
                     tx_done  <= 1'b1;
                     tx_ready <= 1'b1;
                     tx_busy  <= 1'b0;
                     tx       <= 1'b1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               tx       <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: frame shapes, parity, two stop bits,
// back-to-back handshake, mid-frame abort and real baud tick spacing.
module tb_uart_tx_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       stop2 = 1'b0;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int n_checks = 0;
   int n_fail   = 0;
   bit real_ticks = 1'b0;
   int tick_div = 0;

   always #5 clk = ~clk;

   // Constant-high strobe by default; one tick every 326 cycles in real mode.
   always @(negedge clk) begin
      if (!real_ticks) begin
         baud_tick = 1'b1;
         tick_div  = 0;
      end else begin
         tick_div  = (tick_div == 325) ? 0 : tick_div + 1;
         baud_tick = (tick_div == 0);
      end
   end

   uart_tx_core dut (
      .clk        (clk),
      .rst        (rst),
      .baud_tick  (baud_tick),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   // Drives a transfer in cycle 0; returns at the sample point of cycle 1.
   task automatic send(input logic [7:0] d, input logic pen, input logic podd, input logic s2);
      @(negedge clk);
      tx_data = d; parity_en = pen; parity_odd = podd; stop2 = s2; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_checks++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
      n_checks++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
      n_checks++;
      if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
      rst = 1'b0;
   endtask

   task automatic test_8n1();
      logic [9:0] pat;
      int dones;
      pat = 10'b1_10100101_0;   // stop, data 0xA5 MSB..LSB, start
      dones = 0;
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
         n_fail++; $display("FAIL 8n1_busy_c1: busy=%b ready=%b want 1/0", tx_busy, tx_ready);
      end
      for (int c = 1; c <= 160; c++) begin
         if (c > 1) @(negedge clk);
         n_checks++;
         if (tx !== pat[(c-1)/16]) begin
            n_fail++; $display("FAIL 8n1_tx: cycle %0d got %b want %b", c, tx, pat[(c-1)/16]);
         end
         if (tx_done) dones++;
      end
      @(negedge clk);
      n_checks++;
      if (tx_done !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++; $display("FAIL 8n1_end_c161: done=%b ready=%b busy=%b tx=%b want 1/1/0/1",
                            tx_done, tx_ready, tx_busy, tx);
      end
      n_checks++;
      if (dones != 0) begin n_fail++; $display("FAIL 8n1_early_done: got %0d pulses want 0", dones); end
      @(negedge clk);
      n_checks++;
      if (tx_done !== 1'b0) begin n_fail++; $display("FAIL 8n1_done_width: got %b want 0", tx_done); end
   endtask

   task automatic test_parity();
      logic [10:0] pat;
      for (int k = 0; k < 2; k++) begin
         // 0x07 has three ones: even parity bit 1, odd parity bit 0
         pat = (k == 0) ? 11'b1_1_00000111_0 : 11'b1_0_00000111_0;
         send(8'h07, 1'b1, k[0], 1'b0);
         for (int c = 1; c <= 176; c++) begin
            if (c > 1) @(negedge clk);
            n_checks++;
            if (tx !== pat[(c-1)/16]) begin
               n_fail++; $display("FAIL parity%0d_tx: cycle %0d got %b want %b", k, c, tx, pat[(c-1)/16]);
            end
         end
         @(negedge clk);
         n_checks++;
         if (tx_done !== 1'b1) begin n_fail++; $display("FAIL parity%0d_done_c177: got %b want 1", k, tx_done); end
      end
   endtask

   task automatic test_stop2();
      logic [10:0] pat;
      int dones;
      pat = 11'b11_11111111_0;
      dones = 0;
      send(8'hFF, 1'b0, 1'b0, 1'b1);
      for (int c = 1; c <= 176; c++) begin
         if (c > 1) @(negedge clk);
         n_checks++;
         if (tx !== pat[(c-1)/16] || tx_busy !== 1'b1) begin
            n_fail++; $display("FAIL stop2_tx: cycle %0d tx=%b busy=%b want %b/1", c, tx, tx_busy, pat[(c-1)/16]);
         end
         if (tx_done) dones++;
      end
      @(negedge clk);
      n_checks++;
      if (tx_done !== 1'b1 || dones != 0) begin
         n_fail++; $display("FAIL stop2_done_c177: done=%b early=%0d want 1/0", tx_done, dones);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] pat_a, pat_b;
      pat_a = 10'b1_01010101_0;
      pat_b = 10'b1_00111100_0;
      @(negedge clk);
      tx_data = 8'h55; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h3C;   // valid stays high through the whole first frame
      for (int c = 1; c <= 160; c++) begin
         if (c > 1) @(negedge clk);
         n_checks++;
         if (tx !== pat_a[(c-1)/16] || tx_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: cycle %0d tx=%b ready=%b want %b/0", c, tx, tx_ready, pat_a[(c-1)/16]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (tx_done !== 1'b1 || tx_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_handoff_c161: done=%b ready=%b want 1/1", tx_done, tx_ready);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      for (int c = 162; c <= 321; c++) begin
         if (c > 162) @(negedge clk);
         n_checks++;
         if (tx !== pat_b[(c-162)/16] || tx_busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: cycle %0d tx=%b busy=%b want %b/1", c, tx, tx_busy, pat_b[(c-162)/16]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (tx_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_c322: got %b want 1", tx_done); end
   endtask

   task automatic test_abort();
      logic [9:0] pat;
      int dones;
      pat = 10'b1_00001111_0;
      dones = 0;
      send(8'h0F, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 70; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 30) begin tx_data = 8'hF0; tx_valid = 1'b1; stop2 = 1'b1; end
         if (c == 50) tx_valid = 1'b0;
         if (c == 55) tx_valid = 1'b1;
         n_checks++;
         if (tx !== pat[(c-1)/16] || tx_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_inflight: cycle %0d tx=%b ready=%b want %b/0", c, tx, tx_ready, pat[(c-1)/16]);
         end
         if (tx_done) dones++;
      end
      rst = 1'b1; tx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         n_fail++; $display("FAIL abort_c71: tx=%b ready=%b busy=%b done=%b want 1/1/0/0",
                            tx, tx_ready, tx_busy, tx_done);
      end
      for (int c = 72; c <= 250; c++) begin
         @(negedge clk);
         if (tx_done || tx !== 1'b1) dones++;
      end
      n_checks++;
      if (dones != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d bad cycles want 0", dones); end
      stop2 = 1'b0;
   endtask

   task automatic test_real_ticks();
      int edges[$];
      int cyc;
      logic last;
      real_ticks = 1'b1;
      repeat (2) @(negedge clk);
      send(8'h55, 1'b0, 1'b0, 1'b0);
      cyc  = 1;
      last = tx;
      // 0x55 toggles every data bit, so each edge marks a bit boundary
      while (edges.size() < 6 && cyc < 8 * 5216) begin
         @(negedge clk);
         cyc++;
         if (tx !== last) begin edges.push_back(cyc); last = tx; end
      end
      n_checks++;
      if (edges.size() < 6) begin
         n_fail++; $display("FAIL real_timeout: got %0d edges want 6", edges.size());
      end else begin
         n_checks++;
         if (edges[0] - 1 <= 15 * 326 || edges[0] - 1 > 16 * 326) begin
            n_fail++; $display("FAIL real_start_len: got %0d want (4890,5216]", edges[0] - 1);
         end
         for (int i = 1; i < 6; i++) begin
            n_checks++;
            if (edges[i] - edges[i-1] != 16 * 326) begin
               n_fail++; $display("FAIL real_bit%0d_len: got %0d want 5216", i - 1, edges[i] - edges[i-1]);
            end
         end
      end
      rst = 1'b1;
      real_ticks = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_stop2();
      test_back_to_back();
      test_abort();
      test_real_ticks();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
